// File: rtl/cskipa_pkg.sv
// Shared constants and block-partitioning helpers for the pipelined carry-skip adder.
package cskipa_pkg;

  localparam int unsigned DefBlk = 4;

  // Number of skip blocks needed to cover one segment.
  function automatic int unsigned num_blk(input int unsigned seg, input int unsigned blk);
    return (seg + blk - 1) / blk;
  endfunction

  // Width of the final block of a segment; shorter than blk when blk does not divide seg.
  function automatic int unsigned last_blk_w(input int unsigned seg, input int unsigned blk);
    return seg - (num_blk(seg, blk) - 1) * blk;
  endfunction

endpackage

// File: rtl/cskip_block.sv
// One carry-skip block: N-bit ripple adder whose carry-out bypasses the ripple when all bits
// propagate.
module cskip_block #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         prop
);

  logic [N:0] w_c;

  // Ripple-carry sum across the block.
  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]    = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign prop = &(a ^ b);
  // Skip mux: a fully propagating block passes its carry-in straight through.
  assign cout = prop ? cin : w_c[N];

endmodule

// File: rtl/cskipa_pipe.sv
// Pipelined carry-skip adder/subtractor with an elastic valid/ready handshake.
// Stage k adds segment k; its carry, the finished low sum bits and the still-unused operand
// bits are registered and handed to stage k+1.
module cskipa_pipe
  import cskipa_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLK    = DefBlk,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned NB   = num_blk(SEG, BLK);
  localparam int unsigned LB   = last_blk_w(SEG, BLK);
  localparam int unsigned LAST = STAGES - 1;

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("cskipa_pipe: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_cmsb;

  logic [STAGES:0]   w_ready;
  logic [STAGES-1:0] w_valid_in;
  logic [STAGES-1:0] w_carry_in;
  logic [WIDTH-1:0]  w_a_in   [STAGES];
  logic [WIDTH-1:0]  w_b_in   [STAGES];
  logic [WIDTH-1:0]  w_sum_in [STAGES];

  assign w_ready[STAGES] = i_ready;
  assign o_ready         = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   w_seg_sum;
    logic [NB:0]      w_blk_c;
    logic [NB-1:0]    w_blk_p;
    logic             w_seg_cout;
    logic             w_load;
    logic [WIDTH-1:0] w_sum_next;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1, so the carry-in is forced high.
      assign w_valid_in[k] = i_valid;
      assign w_carry_in[k] = i_sub | i_cin;
      assign w_a_in[k]     = i_add_term1;
      assign w_b_in[k]     = i_add_term2 ^ {WIDTH{i_sub}};
      assign w_sum_in[k]   = '0;
    end else begin : g_next
      assign w_valid_in[k] = r_valid[k-1];
      assign w_carry_in[k] = r_carry[k-1];
      assign w_a_in[k]     = r_a[k-1];
      assign w_b_in[k]     = r_b[k-1];
      assign w_sum_in[k]   = r_sum[k-1];
    end

    // A stage can take new data when empty or when its content moves on this cycle.
    assign w_ready[k] = ~r_valid[k] | w_ready[k+1];
    assign w_load     = w_ready[k] & w_valid_in[k];

    assign w_blk_c[0] = w_carry_in[k];
    for (genvar j = 0; j < NB; j++) begin : g_blk
      localparam int unsigned BW = (j == NB - 1) ? LB : BLK;
      localparam int unsigned LO = k * SEG + j * BLK;
      cskip_block #(
        .N(BW)
      ) u_blk (
        .a   (w_a_in[k][LO +: BW]),
        .b   (w_b_in[k][LO +: BW]),
        .cin (w_blk_c[j]),
        .sum (w_seg_sum[j*BLK +: BW]),
        .cout(w_blk_c[j+1]),
        .prop(w_blk_p[j])
      );
    end

    // Segment-level skip: a fully propagating segment forwards its carry-in.
    assign w_seg_cout = (&w_blk_p) ? w_carry_in[k] : w_blk_c[NB];

    // Merge this segment's sum into the partial result.
    always_comb begin
      w_sum_next                 = w_sum_in[k];
      w_sum_next[k*SEG +: SEG]   = w_seg_sum;
    end

    // Stage register: valid follows upstream when ready, data only on a transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_valid[k] <= 1'b0;
        r_carry[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
      end else begin
        if (w_ready[k]) begin
          r_valid[k] <= w_valid_in[k];
        end
        if (w_load) begin
          r_carry[k] <= w_seg_cout;
          r_a[k]     <= w_a_in[k];
          r_b[k]     <= w_b_in[k];
          r_sum[k]   <= w_sum_next;
        end
      end
    end

    if (k == LAST) begin : g_msb
      // Carry into the MSB, recovered from the MSB sum bit, for the overflow flag.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cmsb <= 1'b0;
        end else if (w_load) begin
          r_cmsb <= w_a_in[k][WIDTH-1] ^ w_b_in[k][WIDTH-1] ^ w_seg_sum[SEG-1];
        end
      end
    end
  end

  assign o_valid = r_valid[LAST];
  assign o_sum   = r_sum[LAST];
  assign o_cout  = r_carry[LAST];
  assign o_ovf   = r_cmsb ^ r_carry[LAST];

endmodule

// File: tb/tb_cskipa_pipe.sv
// Self-checking bench for cskipa_pipe: directed corner cases, backpressure and random
// streaming on three configurations against an arithmetic reference model.
module tb_cskipa_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT0: WIDTH=32, BLK=4, STAGES=2
  logic        v0, r0, cin0, sub0, ov0, rd0, co0, of0;
  logic [31:0] a0, b0, s0;
  // DUT1: WIDTH=22, BLK=4, STAGES=2
  logic        v1, r1, cin1, sub1, ov1, rd1, co1, of1;
  logic [21:0] a1, b1, s1;
  // DUT2: WIDTH=22, BLK=4, STAGES=1
  logic        v2, r2, cin2, sub2, ov2, rd2, co2, of2;
  logic [21:0] a2, b2, s2;

  cskipa_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(r0), .i_add_term1(a0),
    .i_add_term2(b0), .i_cin(cin0), .i_sub(sub0), .o_valid(ov0), .i_ready(rd0),
    .o_sum(s0), .o_cout(co0), .o_ovf(of0)
  );
  cskipa_pipe #(.WIDTH(22), .BLK(4), .STAGES(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1), .i_add_term1(a1),
    .i_add_term2(b1), .i_cin(cin1), .i_sub(sub1), .o_valid(ov1), .i_ready(rd1),
    .o_sum(s1), .o_cout(co1), .o_ovf(of1)
  );
  cskipa_pipe #(.WIDTH(22), .BLK(4), .STAGES(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(r2), .i_add_term1(a2),
    .i_add_term2(b2), .i_cin(cin2), .i_sub(sub2), .o_valid(ov2), .i_ready(rd2),
    .o_sum(s2), .o_cout(co2), .o_ovf(of2)
  );

  // Reference: {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub, input int w);
    longint unsigned m, ua, ub, r;
    logic c, o, sa, sb, sr;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    if (sub) begin
      r = (ua - ub) & m;
      c = (ua >= ub);
    end else begin
      r = ua + ub + {63'd0, cin};
      c = r[w];
      r = r & m;
    end
    sa = ua[w-1];
    sb = ub[w-1];
    sr = r[w-1];
    o  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {o, c, r[31:0]};
  endfunction

  // Random operand biased toward carry-chain corner values.
  function automatic logic [31:0] rnd_op(input int w);
    logic [31:0] m, r;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       r = 32'd0;
      1:       r = m;
      2:       r = (m >> 1) + 32'd1;
      3:       r = m >> 1;
      default: r = $urandom;
    endcase
    return r & m;
  endfunction

  // Send one operation into DUT0 (pipeline empty) and wait for its result.
  task automatic xfer_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, output int lat, output logic [31:0] s,
                          output logic c, output logic o);
    lat = -1; s = '0; c = 1'b0; o = 1'b0;
    @(negedge clk);
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; v0 = 1'b1; rd0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (ov0) begin
        lat = i; s = s0; c = co0; o = of0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit seen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ov0); end
    total++; if (s0 !== 32'd0) begin bad++; $display("FAIL rst_sum: got %h want 0", s0); end
    total++; if (co0 !== 1'b0) begin bad++; $display("FAIL rst_cout: got %b want 0", co0); end
    total++; if (of0 !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", of0); end
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", r0); end
    // Two operations in flight, downstream stalled.
    rd0 = 1'b0; v0 = 1'b1; a0 = 32'd10; b0 = 32'd20; cin0 = 1'b0; sub0 = 1'b0;
    @(negedge clk);
    a0 = 32'd30; b0 = 32'd40;
    @(negedge clk);
    v0 = 1'b0;
    #1;
    total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL rst_prefill_valid: got %b want 1", ov0); end
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL rst_prefill_ready: got %b want 0", r0); end
    rst = 1'b1;
    #1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want 0", ov0); end
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL rst_async_ready: got %b want 1", r0); end
    total++; if (s0 !== 32'd0) begin bad++; $display("FAIL rst_async_sum: got %h want 0", s0); end
    @(negedge clk);
    rst = 1'b0; rd0 = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (ov0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rst_no_result: got 1 want 0"); end
  endtask

  task automatic test_prop;
    int lat; logic [31:0] s; logic c, o;
    xfer_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, lat, s, c, o);
    total++; if (lat != 2) begin bad++; $display("FAIL prop_latency: got %0d want 2", lat); end
    total++; if (s !== 32'h0) begin bad++; $display("FAIL prop_sum: got %h want 00000000", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL prop_cout: got %b want 1", c); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL prop_ovf: got %b want 0", o); end
  endtask

  task automatic test_sub;
    int lat; logic [31:0] s; logic c, o;
    xfer_one(32'd5, 32'd7, 1'b0, 1'b1, lat, s, c, o);
    total++; if (s !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub1_sum: got %h want fffffffe", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL sub1_cout: got %b want 0", c); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL sub1_ovf: got %b want 0", o); end
    xfer_one(32'h8000_0000, 32'd1, 1'b1, 1'b1, lat, s, c, o);
    total++; if (s !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub2_sum: got %h want 7fffffff", s); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL sub2_ovf: got %b want 1", o); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL sub2_cout: got %b want 1", c); end
  endtask

  task automatic test_ovf;
    int lat; logic [31:0] s; logic c, o;
    xfer_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat, s, c, o);
    total++; if (s !== 32'h8000_0000) begin bad++; $display("FAIL ovf_sum: got %h want 80000000", s); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", o); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL ovf_cout: got %b want 0", c); end
  endtask

  task automatic test_back_to_back;
    logic [33:0] q[$];
    logic [33:0] e;
    int sent, got, last;
    bit stalled;
    sent = 0; got = 0; last = -1; stalled = 1'b0; rd0 = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 20; cyc++) begin
      @(negedge clk);
      v0 = (sent < 20); a0 = rnd_op(32); b0 = rnd_op(32);
      cin0 = 1'($urandom_range(0, 1)); sub0 = 1'($urandom_range(0, 1));
      #1;
      if (v0 && !r0) stalled = 1'b1;
      if (ov0) begin
        total++;
        e = (q.size() > 0) ? q.pop_front() : '0;
        if ({of0, co0, s0} !== e) begin
          bad++; $display("FAIL b2b_result: got %h want %h", {of0, co0, s0}, e);
        end
        got++; last = cyc;
      end
      if (v0 && r0) begin q.push_back(model(a0, b0, cin0, sub0, 32)); sent++; end
    end
    v0 = 1'b0;
    total++; if (stalled) begin bad++; $display("FAIL b2b_ready: got 0 want 1"); end
    total++; if (got != 20) begin bad++; $display("FAIL b2b_count: got %0d want 20", got); end
    total++; if (last != 21) begin bad++; $display("FAIL b2b_last_cycle: got %0d want 21", last); end
  endtask

  task automatic test_backpressure;
    logic [31:0] av[6], bv[6], held;
    logic [33:0] q[$];
    logic [33:0] e;
    int sent, got;
    bit saw_nr, hold;
    sent = 0; got = 0; saw_nr = 1'b0; hold = 1'b0; held = '0;
    for (int i = 0; i < 6; i++) begin av[i] = rnd_op(32); bv[i] = rnd_op(32); end
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (hold) begin
        total++;
        if (!(ov0 === 1'b1 && s0 === held)) begin
          bad++; $display("FAIL bp_stall_hold: got v=%b sum=%h want v=1 sum=%h", ov0, s0, held);
        end
      end
      v0 = (sent < 6);
      a0 = av[(sent < 6) ? sent : 0]; b0 = bv[(sent < 6) ? sent : 0];
      cin0 = 1'b0; sub0 = 1'b0;
      rd0 = !(cyc >= 3 && cyc < 7);
      #1;
      if (!rd0 && !r0) saw_nr = 1'b1;
      hold = ov0 && !rd0;
      held = s0;
      if (ov0 && rd0) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra: got result %h want none", s0);
        end else begin
          e = q.pop_front();
          if ({of0, co0, s0} !== e) begin
            bad++; $display("FAIL bp_order: got %h want %h", {of0, co0, s0}, e);
          end
        end
        got++;
      end
      if (v0 && r0) begin q.push_back(model(a0, b0, cin0, sub0, 32)); sent++; end
    end
    v0 = 1'b0; rd0 = 1'b1;
    total++; if (!saw_nr) begin bad++; $display("FAIL bp_ready_low: got 1 want 0"); end
    total++; if (got != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL bp_lost: got %0d left want 0", q.size()); end
  endtask

  task automatic test_random;
    logic [33:0] q0[$], q1[$], q2[$];
    logic [33:0] e;
    logic [31:0] ta, tb;
    bit drain;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      drain = (cyc >= 10000);
      @(negedge clk);
      ta = rnd_op(32); tb = rnd_op(32);
      v0 = !drain && ($urandom_range(0, 9) < 7); a0 = ta; b0 = tb;
      cin0 = 1'($urandom_range(0, 1)); sub0 = 1'($urandom_range(0, 1));
      rd0 = drain || ($urandom_range(0, 9) < 7);
      ta = rnd_op(22); tb = rnd_op(22);
      v1 = !drain && ($urandom_range(0, 9) < 7); a1 = ta[21:0]; b1 = tb[21:0];
      cin1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      rd1 = drain || ($urandom_range(0, 9) < 7);
      ta = rnd_op(22); tb = rnd_op(22);
      v2 = !drain && ($urandom_range(0, 9) < 7); a2 = ta[21:0]; b2 = tb[21:0];
      cin2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
      rd2 = drain || ($urandom_range(0, 9) < 7);
      #1;
      if (ov0 && rd0) begin
        total++;
        e = (q0.size() > 0) ? q0.pop_front() : '1;
        if ({of0, co0, s0} !== e) begin
          bad++; $display("FAIL rand32: got %h want %h", {of0, co0, s0}, e);
        end
      end
      if (ov1 && rd1) begin
        total++;
        e = (q1.size() > 0) ? q1.pop_front() : '1;
        if ({of1, co1, s1} !== {e[33], e[32], e[21:0]}) begin
          bad++; $display("FAIL rand22s2: got %h want %h", {of1, co1, s1}, {e[33], e[32], e[21:0]});
        end
      end
      if (ov2 && rd2) begin
        total++;
        e = (q2.size() > 0) ? q2.pop_front() : '1;
        if ({of2, co2, s2} !== {e[33], e[32], e[21:0]}) begin
          bad++; $display("FAIL rand22s1: got %h want %h", {of2, co2, s2}, {e[33], e[32], e[21:0]});
        end
      end
      if (v0 && r0) q0.push_back(model(a0, b0, cin0, sub0, 32));
      if (v1 && r1) q1.push_back(model({10'd0, a1}, {10'd0, b1}, cin1, sub1, 22));
      if (v2 && r2) q2.push_back(model({10'd0, a2}, {10'd0, b2}, cin2, sub2, 22));
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    total++; if (q0.size() != 0) begin bad++; $display("FAIL rand32_lost: got %0d want 0", q0.size()); end
    total++; if (q1.size() != 0) begin bad++; $display("FAIL rand22s2_lost: got %0d want 0", q1.size()); end
    total++; if (q2.size() != 0) begin bad++; $display("FAIL rand22s1_lost: got %0d want 0", q2.size()); end
  endtask

  initial begin
    v0 = 1'b0; rd0 = 1'b1; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    v1 = 1'b0; rd1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    v2 = 1'b0; rd2 = 1'b1; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    test_reset();
    test_prop();
    test_sub();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
